// File: rtl/ssd_score_scan.sv
// Seven-segment score display: double-dabble BCD conversion plus multiplexed anode/cathode scan.
// Optional leading-zero blanking is enabled by defining SSD_LZB_EN.
module ssd_score_scan #(
    parameter int NUM_DIGITS    = 4,
    parameter int VAL_W         = 14,
    parameter int SCAN_DIV_BITS = 18,
    parameter int BLANK_CYC     = 16
) (
    input  logic                  board_clk,
    input  logic                  Reset,
    input  logic [VAL_W-1:0]      Value,
    input  logic                  Load,
    output logic                  Busy,
    input  logic [NUM_DIGITS-1:0] Digit_En,
    input  logic [NUM_DIGITS-1:0] Dp_Mask,
    output logic                  Overflow,
    output logic [NUM_DIGITS-1:0] An,
    output logic [7:0]            Cath
);

    localparam int BD = (VAL_W + 2) / 3;
    localparam int BW = 4 * BD;
    localparam int DW = 4 * NUM_DIGITS;
    localparam int PW = (BW > DW) ? BW : DW;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(VAL_W);

    localparam logic [IW-1:0]            LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0]            LAST_IT   = CW'(VAL_W - 1);
    localparam logic [SCAN_DIV_BITS-1:0] BLANK_END = SCAN_DIV_BITS'(BLANK_CYC);

    // state   | meaning
    // S_IDLE  | waiting for Load
    // S_CONV  | one double-dabble iteration per clock
    // S_LATCH | publish BCD digits and overflow to the display register
    typedef enum logic [1:0] {S_IDLE, S_CONV, S_LATCH} state_t;

    state_t                   state;
    logic [VAL_W-1:0]         shreg;
    logic [BW-1:0]            bcd;
    logic [BW-1:0]            bcd_adj;
    logic [PW-1:0]            bcd_pad;
    logic [CW-1:0]            iter;
    logic [DW-1:0]            disp;

    logic [SCAN_DIV_BITS-1:0] presc;
    logic [IW-1:0]            idx;
    logic [3:0]               nib;
    logic [6:0]               seg;
    logic [6:0]               seg_eff;
    logic [NUM_DIGITS-1:0]    lzb;
    logic                     lit;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BD; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Zero-pad so digits beyond the converter width read as 0 and overflow is just the upper slice.
    assign bcd_pad = PW'(bcd);

    always_ff @(posedge board_clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bcd      <= '0;
            iter     <= '0;
            disp     <= '0;
            Overflow <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Load) begin
                        shreg <= Value;
                        bcd   <= '0;
                        iter  <= LAST_IT;
                        Busy  <= 1'b1;
                        state <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd   <= {bcd_adj[BW-2:0], shreg[VAL_W-1]};
                    shreg <= {shreg[VAL_W-2:0], 1'b0};
                    if (iter == '0)
                        state <= S_LATCH;
                    else
                        iter <= iter - 1'b1;
                end
                S_LATCH: begin
                    disp     <= bcd_pad[DW-1:0];
                    Overflow <= |(bcd_pad >> DW);
                    Busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign nib = disp[4*idx +: 4];

    always_comb begin
        case (nib)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    end

`ifdef SSD_LZB_EN
    logic seen;

    // A digit is blank when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        lzb  = '0;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            seen   = seen | (disp[4*i +: 4] != 4'd0);
            lzb[i] = ~seen;
        end
    end
`else
    assign lzb = '0;
`endif

    always_comb begin
        if (Overflow)
            seg_eff = 7'b1111110;
        else if (lzb[idx])
            seg_eff = 7'b1111111;
        else
            seg_eff = seg;
    end

    assign lit = (presc >= BLANK_END) && Digit_En[idx];

    always_ff @(posedge board_clk) begin
        if (Reset) begin
            presc <= '0;
            idx   <= '0;
            An    <= '1;
            Cath  <= 8'hFF;
        end else begin
            presc <= presc + 1'b1;
            if (&presc)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            An   <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            Cath <= {seg_eff, ~Dp_Mask[idx]};
        end
    end

endmodule

// File: tb/tb_ssd_score_scan.sv
// Scoreboarded bench for ssd_score_scan: decimal reference model, per-cycle anode/cathode checks.
module tb_ssd_score_scan;

    localparam int ND   = 4;
    localparam int VW   = 14;
    localparam int SDB  = 4;
    localparam int BC   = 2;
    localparam int SLOT = 1 << SDB;

    logic          board_clk = 1'b0;
    logic          Reset     = 1'b1;
    logic [VW-1:0] Value     = '0;
    logic          Load      = 1'b0;
    logic          Busy;
    logic [ND-1:0] Digit_En  = 4'hF;
    logic [ND-1:0] Dp_Mask   = 4'h0;
    logic          Overflow;
    logic [ND-1:0] An;
    logic [7:0]    Cath;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int stim_cyc = 0;
    int last_acc = -1000;

    always #5 board_clk = ~board_clk;

    ssd_score_scan #(
        .NUM_DIGITS(ND), .VAL_W(VW), .SCAN_DIV_BITS(SDB), .BLANK_CYC(BC)
    ) dut (
        .board_clk(board_clk), .Reset(Reset), .Value(Value), .Load(Load),
        .Busy(Busy), .Digit_En(Digit_En), .Dp_Mask(Dp_Mask),
        .Overflow(Overflow), .An(An), .Cath(Cath)
    );

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] exp_cath(int val, int pos, logic dp);
        int p;
        logic [6:0] s;
        p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
        if (val > 9999) s = 7'b1111110;
        else begin
            s = seg_of((val / p) % 10);
`ifdef SSD_LZB_EN
            if (pos > 0 && val < p) s = 7'b1111111;
`endif
        end
        return {s, ~dp};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge board_clk);
        #1;
        stim_cyc++;
    endtask

    // A load is accepted only if the previous accepted one was at least VW+2 cycles ago.
    task automatic do_load(int v);
        Value = VW'(v);
        Load  = 1'b1;
        if (stim_cyc >= last_acc + VW + 2) begin
            last_acc = stim_cyc;
            exp_q.push_back(v);
        end
        step();
        Load = 1'b0;
    endtask

    task automatic do_reset(int n);
        Reset = 1'b1;
        repeat (n) step();
        Reset    = 1'b0;
        last_acc = -1000;
    endtask

    initial begin : monitor
        int       cyc;
        bit       was_rst, rec_valid, prev_busy;
        int       busy_len, disp_val;
        int       rec_psc, rec_idx, rec_val;
        logic [3:0] rec_en, rec_dp, exp_an;
        logic     rec_lit;
        cyc = 0; was_rst = 0; rec_valid = 0; prev_busy = 0;
        busy_len = 0; disp_val = 0;
        rec_psc = 0; rec_idx = 0; rec_val = 0; rec_en = '0; rec_dp = '0;
        forever begin
            @(negedge board_clk);
            if (Reset) begin
                was_rst = 1; rec_valid = 0; cyc = 0; disp_val = 0;
                busy_len = 0; prev_busy = 0;
                exp_q.delete();
                continue;
            end
            if (was_rst) begin
                check("rst_an", An, 4'hF);
                check("rst_cath", Cath, 8'hFF);
                check("rst_busy", Busy, 0);
                check("rst_ovf", Overflow, 0);
                was_rst = 0;
            end else if (rec_valid) begin
                rec_lit = (rec_psc >= BC) && rec_en[rec_idx];
                exp_an  = rec_lit ? ~(4'b0001 << rec_idx) : 4'hF;
                check("an", An, exp_an);
                if (rec_lit) check("cath", Cath, exp_cath(rec_val, rec_idx, rec_dp[rec_idx]));
            end
            if (Busy) begin
                busy_len++;
                if (busy_len == VW + 2) check("busy_len_bound", busy_len, VW + 1);
            end else if (prev_busy) begin
                check("busy_len", busy_len, VW + 1);
                check("resp_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) disp_val = exp_q.pop_front();
                busy_len = 0;
            end
            prev_busy = Busy;
            check("ovf", Overflow, disp_val > 9999);
            rec_psc   = cyc % SLOT;
            rec_idx   = (cyc / SLOT) % ND;
            rec_en    = Digit_En;
            rec_dp    = Dp_Mask;
            rec_val   = disp_val;
            rec_valid = 1;
            cyc++;
        end
    end

    initial begin : stimulus
        #1;
        do_reset(3);
        repeat (20) step();

        do_load(1234);
        repeat (90) step();
        do_load(10000);
        repeat (90) step();
        do_load(7);
        repeat (90) step();

        do_load(42);
        repeat (4) step();
        do_load(99);
        repeat (2) step();
        do_reset(2);
        repeat (80) step();

        Digit_En = 4'b0101;
        Dp_Mask  = 4'b0100;
        do_load(9999);
        repeat (140) step();
        do_load(16383);
        repeat (80) step();
        do_load(0);
        repeat (80) step();

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                Digit_En = 4'($urandom);
                Dp_Mask  = 4'($urandom);
            end
            do_load(int'($urandom_range(0, 16383)));
            repeat ($urandom_range(3, 45)) step();
        end
        repeat (40) step();

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
